// File: rtl/spypath_meter_pkg.sv
// Shared constants and FSM state type for the spy-path delay meter.
package spypath_meter_pkg;

  localparam int unsigned DEF_CNT_W       = 16;
  localparam int unsigned DEF_TIMEOUT     = 1023;
  localparam int unsigned MIN_SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_MEASURE,
    ST_DONE
  } meter_state_e;

endpackage

// File: rtl/spypath_sync.sv
// Multi-flop synchronizer bringing the asynchronous chain output into clk.
module spypath_sync
  import spypath_meter_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = MIN_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic sync_o
);

  // Depths below two give no metastability protection, so they are raised.
  localparam int unsigned STAGES = (SYNC_STAGES < MIN_SYNC_STAGES) ? MIN_SYNC_STAGES : SYNC_STAGES;

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], async_i};
    end
  end

  assign sync_o = sync_q[STAGES-1];

endmodule

// File: rtl/spypath_delay_meter.sv
// Launches an edge into an external spy-path chain and counts cycles until
// the synchronized capture returns the same level, with timeout and error.
module spypath_delay_meter
  import spypath_meter_pkg::*;
#(
  parameter int unsigned CNT_W       = DEF_CNT_W,
  parameter int unsigned TIMEOUT     = DEF_TIMEOUT,
  parameter int unsigned SYNC_STAGES = MIN_SYNC_STAGES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             start_ready,
  output logic             path_launch,
  input  logic             path_capture,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [CNT_W-1:0] result_delay,
  output logic             result_timeout,
  output logic             result_error
);

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  meter_state_e     state_q, state_d;
  logic             launch_q, launch_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] res_delay_q, res_delay_d;
  logic             res_timeout_q, res_timeout_d;
  logic             res_error_q, res_error_d;
  logic             capture_sync;

  spypath_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .async_i(path_capture),
    .sync_o (capture_sync)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      launch_q      <= 1'b0;
      cnt_q         <= '0;
      res_delay_q   <= '0;
      res_timeout_q <= 1'b0;
      res_error_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      launch_q      <= launch_d;
      cnt_q         <= cnt_d;
      res_delay_q   <= res_delay_d;
      res_timeout_q <= res_timeout_d;
      res_error_q   <= res_error_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    launch_d      = launch_q;
    cnt_d         = cnt_q;
    res_delay_d   = res_delay_q;
    res_timeout_d = res_timeout_q;
    res_error_d   = res_error_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (capture_sync == launch_q) begin
            state_d = ST_LAUNCH;
          end else begin
            state_d       = ST_DONE;
            res_delay_d   = '0;
            res_timeout_d = 1'b0;
            res_error_d   = 1'b1;
          end
        end
      end
      ST_LAUNCH: begin
        launch_d = ~launch_q;
        cnt_d    = '0;
        state_d  = ST_MEASURE;
      end
      ST_MEASURE: begin
        if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        // A match in the timeout cycle still counts as a clean measurement.
        if (capture_sync == launch_q) begin
          state_d       = ST_DONE;
          res_delay_d   = cnt_q;
          res_timeout_d = 1'b0;
          res_error_d   = 1'b0;
        end else if (cnt_q == TIMEOUT_C) begin
          state_d       = ST_DONE;
          res_delay_d   = TIMEOUT_C;
          res_timeout_d = 1'b1;
          res_error_d   = 1'b0;
        end
      end
      ST_DONE: begin
        if (result_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    start_ready  = (state_q == ST_IDLE);
    result_valid = (state_q == ST_DONE);
  end

  assign path_launch    = launch_q;
  assign result_delay   = res_delay_q;
  assign result_timeout = res_timeout_q;
  assign result_error   = res_error_q;

endmodule

// File: tb/tb_spypath_delay_meter.sv
// Scoreboard bench: a behavioural chain model drives the capture input and
// expected results are derived from chain delay, sync depth and timeout.
module tb_spypath_delay_meter;

  localparam int unsigned CNT_W_P   = 16;
  localparam int unsigned TIMEOUT_P = 20;
  localparam int unsigned SYNC_P    = 2;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic               start_ready;
  logic               path_launch;
  logic               path_capture;
  logic               result_valid;
  logic               result_ready = 1'b0;
  logic [CNT_W_P-1:0] result_delay;
  logic               result_timeout;
  logic               result_error;

  spypath_delay_meter #(
    .CNT_W      (CNT_W_P),
    .TIMEOUT    (TIMEOUT_P),
    .SYNC_STAGES(SYNC_P)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .start_ready   (start_ready),
    .path_launch   (path_launch),
    .path_capture  (path_capture),
    .result_valid  (result_valid),
    .result_ready  (result_ready),
    .result_delay  (result_delay),
    .result_timeout(result_timeout),
    .result_error  (result_error)
  );

  always #5 clk = ~clk;

  // External chain: a D-stage register delay of path_launch, or a forced level.
  logic [31:0] chain = '0;
  int          d_sel = 5;
  bit          force_en = 1'b0;
  bit          force_v = 1'b0;
  always @(posedge clk) chain <= {chain[30:0], path_launch};
  assign path_capture = force_en ? force_v : chain[d_sel-1];

  typedef struct {
    int unsigned delay;
    bit          to;
    bit          err;
    bit          launch;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  bit   model_launch = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: a result is consumed on the edge after valid&ready is seen.
  always begin
    @(negedge clk);
    #1;
    if (rst_n && result_valid && result_ready) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got delay %0d expected no result", result_delay);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("result_delay", 32'(result_delay), 32'(e.delay));
        chk("result_timeout", 32'(result_timeout), 32'(e.to));
        chk("result_error", 32'(result_error), 32'(e.err));
        chk("path_launch_after", 32'(path_launch), 32'(e.launch));
      end
    end
  end

  task automatic run_meas(input int d, input bit fen, input bit fv, input bit stall);
    exp_t        e;
    int unsigned lat;
    int          waited;
    logic [CNT_W_P-1:0] d0;
    logic        t0, e0, l0;
    d_sel    = d;
    force_en = fen;
    force_v  = fv;
    repeat (40) @(negedge clk);
    if (fen && (fv != model_launch)) begin
      e.delay  = 0;
      e.to     = 1'b0;
      e.err    = 1'b1;
      e.launch = model_launch;
    end else begin
      // A forced level equal to the old launch can never match the new one.
      lat = fen ? TIMEOUT_P + 1 : d + SYNC_P;
      if (lat <= TIMEOUT_P) begin
        e.delay = lat;
        e.to    = 1'b0;
      end else begin
        e.delay = TIMEOUT_P;
        e.to    = 1'b1;
      end
      e.err        = 1'b0;
      model_launch = ~model_launch;
      e.launch     = model_launch;
    end
    q.push_back(e);
    chk("start_ready_idle", 32'(start_ready), 32'(1));
    start = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    waited = 0;
    while (!result_valid && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!result_valid) begin
      checks++;
      errors++;
      $display("FAIL result_wait: got no result_valid after %0d cycles expected one", waited);
      void'(q.pop_back());
      return;
    end
    if (stall) begin
      d0 = result_delay;
      t0 = result_timeout;
      e0 = result_error;
      l0 = path_launch;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        start = (i == 4);
        chk("stall_valid", 32'(result_valid), 32'(1));
        chk("stall_delay", 32'(result_delay), 32'(d0));
        chk("stall_flags", 32'({result_timeout, result_error, path_launch}), 32'({t0, e0, l0}));
      end
      start        = 1'b1;
      result_ready = 1'b1;
      @(negedge clk);
      start        = 1'b0;
      result_ready = 1'b0;
      chk("idle_after_ready", 32'(start_ready), 32'(1));
      chk("valid_drop_after_ready", 32'(result_valid), 32'(0));
    end else begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      result_ready = 1'b1;
      @(negedge clk);
      result_ready = 1'b0;
    end
  endtask

  task automatic reset_mid();
    d_sel    = 10;
    force_en = 1'b0;
    repeat (40) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_start_ready", 32'(start_ready), 32'(1));
    chk("rst_mid_valid", 32'(result_valid), 32'(0));
    chk("rst_mid_launch", 32'(path_launch), 32'(0));
    chk("rst_mid_delay", 32'(result_delay), 32'(0));
    chk("rst_mid_flags", 32'({result_timeout, result_error}), 32'(0));
    @(negedge clk);
    rst_n        = 1'b1;
    model_launch = 1'b0;
    @(negedge clk);
    chk("rst_mid_ready_after", 32'(start_ready), 32'(1));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_start_ready", 32'(start_ready), 32'(1));
    chk("reset_valid", 32'(result_valid), 32'(0));
    chk("reset_launch", 32'(path_launch), 32'(0));
    chk("reset_delay", 32'(result_delay), 32'(0));
    chk("reset_flags", 32'({result_timeout, result_error}), 32'(0));
    rst_n = 1'b1;
    @(negedge clk);

    run_meas(5, 1'b0, 1'b0, 1'b0);
    run_meas(5, 1'b0, 1'b0, 1'b0);
    run_meas(5, 1'b1, 1'b1, 1'b1);
    run_meas(18, 1'b0, 1'b0, 1'b0);
    run_meas(19, 1'b0, 1'b0, 1'b1);
    run_meas(5, 1'b1, 1'b0, 1'b0);

    for (int i = 0; i < 14; i++) begin
      if ($urandom_range(0, 9) < 7) begin
        run_meas(int'($urandom_range(1, 24)), 1'b0, 1'b0, ($urandom_range(0, 4) == 0));
      end else begin
        run_meas(5, 1'b1, 1'($urandom_range(0, 1)), ($urandom_range(0, 4) == 0));
      end
    end

    reset_mid();
    run_meas(5, 1'b0, 1'b0, 1'b0);

    repeat (5) @(negedge clk);
    chk("queue_drained", 32'(q.size()), 32'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
